// File: rtl/i2c_target_if.sv
// rtl/i2c_target_if.sv - bus pins and register port of the I2C target
interface i2c_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;

    modport slave (
        input  scl_in, sda_in, reg_rdata,
        output sda_oe, reg_addr, reg_wdata, reg_we, busy
    );

    modport master (
        output scl_in, sda_in, reg_rdata,
        input  sda_oe, reg_addr, reg_wdata, reg_we, busy
    );
endinterface

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target with 8-bit register pointer and register-port write/read
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50
) (
    input  logic         clk,
    input  logic         rst,
    i2c_target_if.slave  bus_io
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_WAIT_STOP
    } state_e;

    state_e     state_q, state_d;
    logic       scl_meta_q, scl_sync_q, scl_hist_q;
    logic       sda_meta_q, sda_sync_q, sda_hist_q;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    logic       ack_drv_q, ack_drv_d;
    logic       reload_q, reload_d;

    logic       scl_rise, scl_fall, scl_high, start_det, stop_det;
    logic       last_bit, addr_match;
    logic [7:0] byte_in;

    // Synchronizers idle high so reset release never looks like a bus edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_hist_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_meta_q <= bus_io.scl_in;
            scl_sync_q <= scl_meta_q;
            scl_hist_q <= scl_sync_q;
            sda_meta_q <= bus_io.sda_in;
            sda_sync_q <= sda_meta_q;
            sda_hist_q <= sda_sync_q;
        end
    end

    assign scl_rise  = scl_sync_q & ~scl_hist_q;
    assign scl_fall  = ~scl_sync_q & scl_hist_q;
    assign scl_high  = scl_sync_q & scl_hist_q;
    assign start_det = scl_high & sda_hist_q & ~sda_sync_q;
    assign stop_det  = scl_high & ~sda_hist_q & sda_sync_q;

    assign byte_in    = {shift_q[6:0], sda_sync_q};
    assign last_bit   = scl_rise && (bit_cnt_q == 4'd7);
    // General call and the 10-bit address prefix never match.
    assign addr_match = (byte_in[7:1] == TARGET_ADDR) && (byte_in[7:1] != 7'h00)
                        && (byte_in[7:3] != 5'b11110);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = S_IDLE;
        end else if (start_det) begin
            state_d = S_ADDR;
        end else begin
            case (state_q)
                S_ADDR:      if (last_bit) state_d = addr_match ? S_ADDR_ACK : S_WAIT_STOP;
                S_ADDR_ACK:  if (scl_fall && ack_drv_q) state_d = rw_q ? S_RDATA : S_PTR;
                S_PTR:       if (last_bit) state_d = S_PTR_ACK;
                S_PTR_ACK:   if (scl_fall && ack_drv_q) state_d = S_WDATA;
                S_WDATA:     if (last_bit) state_d = S_WDATA_ACK;
                S_WDATA_ACK: if (scl_fall && ack_drv_q) state_d = S_WDATA;
                S_RDATA:     if (scl_fall && (bit_cnt_q == 4'd8)) state_d = S_RACK;
                S_RACK:      if (scl_rise) state_d = sda_sync_q ? S_WAIT_STOP : S_RDATA;
                default:     state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q + {7'd0, we_q};
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        ack_drv_d = ack_drv_q;
        reload_d  = 1'b0;
        // One cycle after a read ACK the pointer has moved; capture the next byte.
        if (reload_q) begin
            tx_d = bus_io.reg_rdata;
        end
        if (stop_det) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (last_bit) begin
                        ack_drv_d = 1'b0;
                        if (state_q == S_ADDR) begin
                            busy_d = addr_match;
                            rw_d   = sda_sync_q;
                        end else if (state_q == S_PTR) begin
                            ptr_d = byte_in;
                        end else begin
                            we_d    = 1'b1;
                            wdata_d = byte_in;
                        end
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall && !ack_drv_q) begin
                        sda_oe_d  = 1'b1;
                        ack_drv_d = 1'b1;
                    end else if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b0;
                        if (state_q == S_ADDR_ACK && rw_q) begin
                            tx_d      = {bus_io.reg_rdata[6:0], 1'b1};
                            sda_oe_d  = ~bus_io.reg_rdata[7];
                            bit_cnt_d = 4'd1;
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_fall && (bit_cnt_q == 4'd8)) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_fall) begin
                        sda_oe_d  = ~tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b1};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                S_RACK: begin
                    if (scl_rise && !sda_sync_q) begin
                        ptr_d     = ptr_q + 8'd1;
                        reload_d  = 1'b1;
                        bit_cnt_d = 4'd0;
                    end else if (scl_rise) begin
                        busy_d = 1'b0;
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            tx_q      <= 8'hFF;
            ptr_q     <= 8'h00;
            wdata_q   <= 8'h00;
            we_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
            ack_drv_q <= 1'b0;
            reload_q  <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            ack_drv_q <= ack_drv_d;
            reload_q  <= reload_d;
        end
    end

    assign bus_io.sda_oe    = sda_oe_q;
    assign bus_io.reg_addr  = ptr_q;
    assign bus_io.reg_wdata = wdata_q;
    assign bus_io.reg_we    = we_q;
    assign bus_io.busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - randomized bus-master bench for i2c_target against a transaction-level model
module tb_i2c_target;
    localparam int Q = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_target_if bus ();
    logic       m_scl, m_sda;
    logic [7:0] regs [256];
    logic       bd_we;
    logic [7:0] bd_addr, bd_data;

    assign bus.scl_in    = m_scl;
    assign bus.sda_in    = m_sda & ~bus.sda_oe;
    assign bus.reg_rdata = regs[bus.reg_addr];

    always @(posedge clk) begin
        if (bd_we) regs[bd_addr] <= bd_data;
        else if (bus.reg_we) regs[bus.reg_addr] <= bus.reg_wdata;
    end

    i2c_target #(.TARGET_ADDR(7'h50)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    logic [15:0] we_log [$];
    int          oe_hits = 0;
    always @(negedge clk) begin
        if (bus.reg_we) we_log.push_back({bus.reg_addr, bus.reg_wdata});
        if (bus.sda_oe) oe_hits <= oe_hits + 1;
    end

    // Reference model: memory image, pointer, expected write strobes.
    logic [7:0]  exp_mem [256];
    logic [7:0]  exp_ptr;
    logic [15:0] exp_we [$];
    int          we_rd = 0;
    logic [7:0]  wbuf [4];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    tick(Q);
        m_scl = 1'b1; tick(2 * Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        b = bus.sda_in; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
    endtask

    task automatic check_we(input string tag);
        check({tag, "_we_cnt"}, 32'(we_log.size() - we_rd), 32'(exp_we.size()));
        for (int i = 0; i < exp_we.size(); i++) begin
            if (we_rd + i < we_log.size()) check({tag, "_we"}, 32'(we_log[we_rd + i]), 32'(exp_we[i]));
        end
        we_rd = we_log.size();
        exp_we.delete();
    endtask

    task automatic txn_write(input logic [7:0] p, input int n);
        logic ack;
        i2c_start();
        write_byte(8'hA0, ack);
        check("w_addr_ack", 32'(ack), 0);
        check("w_busy", 32'(bus.busy), 1);
        write_byte(p, ack);
        check("w_ptr_ack", 32'(ack), 0);
        exp_ptr = p;
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], ack);
            check("w_data_ack", 32'(ack), 0);
            exp_we.push_back({exp_ptr, wbuf[i]});
            exp_mem[exp_ptr] = wbuf[i];
            exp_ptr = exp_ptr + 8'd1;
        end
        i2c_stop();
        tick(4);
        check("w_busy_end", 32'(bus.busy), 0);
        check("w_reg_addr", 32'(bus.reg_addr), 32'(exp_ptr));
        check_we("w");
    endtask

    task automatic txn_read(input logic set_ptr, input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] v;
        i2c_start();
        if (set_ptr) begin
            write_byte(8'hA0, ack);
            check("r_waddr_ack", 32'(ack), 0);
            write_byte(p, ack);
            check("r_ptr_ack", 32'(ack), 0);
            exp_ptr = p;
            i2c_start();
        end
        write_byte(8'hA1, ack);
        check("r_addr_ack", 32'(ack), 0);
        for (int i = 0; i < n; i++) begin
            read_byte(v);
            check("r_data", 32'(v), 32'(exp_mem[exp_ptr]));
            write_bit(i == n - 1);
            if (i != n - 1) exp_ptr = exp_ptr + 8'd1;
        end
        check("r_oe_after_nack", 32'(bus.sda_oe), 0);
        check("r_busy_after_nack", 32'(bus.busy), 0);
        i2c_stop();
        tick(4);
        check("r_reg_addr", 32'(bus.reg_addr), 32'(exp_ptr));
        check_we("r");
    endtask

    task automatic txn_mismatch(input logic [6:0] a7, input logic rw);
        logic ack;
        int   oe0;
        oe0 = oe_hits;
        i2c_start();
        write_byte({a7, rw}, ack);
        check("m_addr_nack", 32'(ack), 1);
        check("m_busy", 32'(bus.busy), 0);
        if (!rw) begin
            write_byte(8'($urandom), ack);
            check("m_data_nack", 32'(ack), 1);
        end
        i2c_stop();
        tick(4);
        check("m_oe_hits", 32'(oe_hits - oe0), 0);
        check("m_reg_addr", 32'(bus.reg_addr), 32'(exp_ptr));
        check_we("m");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack, seen;
        logic [6:0] a7;
        int         kind, n;
        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; bd_we = 1'b0; bd_addr = 8'h00; bd_data = 8'h00;
        for (int i = 0; i < 256; i++) begin
            bd_we = 1'b1; bd_addr = 8'(i); bd_data = 8'($urandom);
            exp_mem[i] = bd_data;
            tick(1);
        end
        bd_we = 1'b0;
        check("rst_sda_oe", 32'(bus.sda_oe), 0);
        check("rst_reg_addr", 32'(bus.reg_addr), 0);
        check("rst_reg_wdata", 32'(bus.reg_wdata), 0);
        check("rst_reg_we", 32'(bus.reg_we), 0);
        check("rst_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        exp_ptr = 8'h00;
        tick(4);

        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        txn_write(8'h10, 2);
        wbuf[0] = 8'h55; wbuf[1] = 8'h66;
        txn_write(8'h20, 2);
        txn_read(1'b1, 8'h20, 2);
        txn_mismatch(7'h51, 1'b0);
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        txn_write(8'hFF, 2);
        check("wrap_addr", 32'(bus.reg_addr), 32'h01);

        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h40, ack);
        exp_ptr = 8'h40;
        for (int i = 0; i < 4; i++) write_bit(1'($urandom));
        i2c_stop();
        tick(4);
        check("midbyte_busy", 32'(bus.busy), 0);
        check("midbyte_addr", 32'(bus.reg_addr), 32'h40);
        check_we("midbyte");

        wbuf[0] = 8'h12;
        txn_write(8'h30, 1);
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h30, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.sda_oe) seen = 1'b1;
            else tick(1);
        end
        check("rstrd_oe_seen", 32'(seen), 1);
        #3 rst = 1'b1;
        #1 check("rstrd_oe_async", 32'(bus.sda_oe), 0);
        tick(1);
        check("rstrd_reg_addr", 32'(bus.reg_addr), 0);
        check("rstrd_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        exp_ptr = 8'h00;
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        check_we("rstrd");
        wbuf[0] = 8'h9A; wbuf[1] = 8'h01;
        txn_write(8'h05, 2);
        txn_read(1'b1, 8'h05, 2);

        for (int t = 0; t < 30; t++) begin
            kind = int'($urandom_range(0, 3));
            n = int'($urandom_range(1, 4));
            if (kind == 0) begin
                for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
                txn_write(8'($urandom), n);
            end else if (kind == 1) begin
                txn_read(1'b1, 8'($urandom), n);
            end else if (kind == 2) begin
                txn_read(1'b0, 8'h00, n);
            end else begin
                a7 = 7'($urandom);
                if ($urandom_range(0, 3) == 0) a7 = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h78;
                if (a7 == 7'h50) a7 = 7'h51;
                txn_mismatch(a7, 1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
